// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: one bit per cycle shift-add multiply and
// restoring shift-subtract divide, writing the HI/LO result registers.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       MDUop,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam int unsigned AccW = 2 * WIDTH + 1;

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  // Multiply: {carry, product}. Divide: low WIDTH bits hold dividend, then quotient.
  logic [AccW-1:0]   acc_q, acc_d;
  logic [WIDTH:0]    rem_q, rem_d;
  // Multiplicand for multiply, divisor for divide.
  logic [WIDTH-1:0]  opd_q, opd_d;
  // Raw dividend, returned in HI on divide-by-zero.
  logic [WIDTH-1:0]  araw_q, araw_d;
  logic              is_div_q, is_div_d;
  logic              div0_q, div0_d;
  logic              qsign_q, qsign_d;
  logic              rsign_q, rsign_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;

  logic              launch, op_arith, op_signed, op_div, last_iter;
  logic [WIDTH-1:0]  abs_a, abs_b;
  logic [AccW-1:0]   mul_sum;
  logic [WIDTH:0]    div_shift, div_diff;
  logic [2*WIDTH-1:0] prod;

  // Operation decode and operand magnitudes
  always_comb begin
    launch    = start && (state_q == StIdle);
    op_arith  = (MDUop == OpMult) || (MDUop == OpMultu) || (MDUop == OpDiv) || (MDUop == OpDivu);
    op_signed = (MDUop == OpMult) || (MDUop == OpDiv);
    op_div    = (MDUop == OpDiv) || (MDUop == OpDivu);
    abs_a     = (op_signed && A[WIDTH-1]) ? (~A + 1'b1) : A;
    abs_b     = (op_signed && B[WIDTH-1]) ? (~B + 1'b1) : B;
    last_iter = (cnt_q == CntW'(WIDTH - 1));
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (launch && op_arith) state_d = StRun;
      StRun:   if (last_iter) state_d = StFix;
      StFix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q != StIdle);
  end

  // Datapath next-state: operand latch, iteration step, sign fix and writeback
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opd_d    = opd_q;
    araw_d   = araw_q;
    is_div_d = is_div_q;
    div0_d   = div0_q;
    qsign_d  = qsign_q;
    rsign_d  = rsign_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    prod     = acc_q[2*WIDTH-1:0];

    mul_sum   = acc_q + (acc_q[0] ? {1'b0, opd_q, {WIDTH{1'b0}}} : {AccW{1'b0}});
    div_shift = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opd_q};

    unique case (state_q)
      StIdle: begin
        if (launch) begin
          if (op_arith) begin
            cnt_d    = '0;
            acc_d    = {{(WIDTH + 1){1'b0}}, (op_div ? abs_a : abs_b)};
            opd_d    = op_div ? abs_b : abs_a;
            rem_d    = '0;
            araw_d   = A;
            is_div_d = op_div;
            div0_d   = op_div && (B == '0);
            qsign_d  = op_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
            rsign_d  = op_signed && A[WIDTH-1];
          end else if (MDUop == OpMthi) begin
            hi_d = A;
          end else if (MDUop == OpMtlo) begin
            lo_d = A;
          end
        end
      end
      StRun: begin
        cnt_d = cnt_q + 1'b1;
        if (is_div_q) begin
          // Negative trial difference means restore (keep shifted value).
          rem_d              = div_diff[WIDTH] ? div_shift : div_diff;
          acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
          acc_d = mul_sum >> 1;
        end
      end
      StFix: begin
        if (is_div_q) begin
          if (div0_q) begin
            hi_d = araw_q;
            lo_d = '1;
          end else begin
            lo_d = qsign_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
            hi_d = rsign_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
          end
        end else begin
          if (qsign_q) prod = ~acc_q[2*WIDTH-1:0] + 1'b1;
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      opd_q    <= '0;
      araw_q   <= '0;
      is_div_q <= 1'b0;
      div0_q   <= 1'b0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      opd_q    <= opd_d;
      araw_q   <= araw_d;
      is_div_q <= is_div_d;
      div0_q   <= div0_d;
      qsign_q  <= qsign_d;
      rsign_q  <= rsign_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: expected {HI,LO} pairs are queued when
// an operation is issued and compared when the unit drops busy.
module tb_mul_div_unit;

  localparam int unsigned W = 32;

  localparam logic [2:0] OpNone  = 3'd0;
  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;
  localparam logic [2:0] OpRsvd  = 3'd7;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   MDUop;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic [W-1:0] HI;
  logic [W-1:0] LO;

  int errors = 0;
  int checks = 0;

  logic [63:0]  exp_q[$];
  int           cycles;
  logic         held;
  logic [W-1:0] obs_hi;
  logic [W-1:0] obs_lo;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .MDUop (MDUop),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  // Reference model: returns {HI, LO} from native arithmetic.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      OpMult:  begin sq = sa * sb; return sq; end
      OpMultu: begin uq = ua * ub; return uq; end
      OpDiv: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      OpDivu: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Issue one op from a negedge, queue its expectation, wait (bounded) for busy to fall.
  // inject > 0 pulses an MTLO start at that busy cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int inject);
    logic [31:0] ph, pl;
    exp_q.push_back(exp);
    @(negedge clk);
    start = 1'b1; MDUop = op; A = a; B = b;
    ph = HI; pl = LO;
    @(negedge clk);
    start = 1'b0; MDUop = OpNone; A = $urandom; B = $urandom;
    cycles = 0;
    held = 1'b1;
    while (busy === 1'b1 && cycles < 200) begin
      if (HI !== ph || LO !== pl) held = 1'b0;
      cycles++;
      if (cycles == inject) begin
        start = 1'b1; MDUop = OpMtlo; A = 32'h0000_DEAD;
      end else begin
        start = 1'b0; MDUop = OpNone;
      end
      @(negedge clk);
    end
    start = 1'b0; MDUop = OpNone;
    obs_hi = HI;
    obs_lo = LO;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; MDUop = OpNone; A = '0; B = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++;
    if (HI !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h want=0", HI); end
    checks++;
    if (LO !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h want=0", LO); end
    reset = 1'b1;
  endtask

  task automatic test_arith_table();
    logic [2:0]  ops[11];
    logic [31:0] as[11];
    logic [31:0] bs[11];
    logic [63:0] es[11];
    logic [63:0] e;
    ops = '{OpMultu, OpMult, OpMult, OpDiv, OpDivu, OpDiv, OpDiv, OpDivu, OpDiv,
            OpMultu, OpMult};
    as  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFF9, 32'd7, 32'd7,
            32'h8000_0000, 32'd5, 32'hFFFF_FFFB, 32'd0, 32'h8000_0000};
    bs  = '{32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd2, 32'd2, 32'hFFFF_FFFE,
            32'hFFFF_FFFF, 32'd0, 32'd0, 32'h1234_5678, 32'd1};
    es  = '{64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFEB, 64'h4000_0000_0000_0000,
            64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0001_0000_0003, 64'h0000_0001_FFFF_FFFD,
            64'h0000_0000_8000_0000, 64'h0000_0005_FFFF_FFFF, 64'hFFFF_FFFB_FFFF_FFFF,
            64'h0000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000};
    for (int i = 0; i < 11; i++) begin
      run_op(ops[i], as[i], bs[i], es[i], -1);
      e = exp_q.pop_front();
      checks++;
      if ({obs_hi, obs_lo} !== e)
        begin errors++; $display("FAIL arith[%0d] got=%h_%h want=%h", i, obs_hi, obs_lo, e); end
      checks++;
      if (cycles != 33)
        begin errors++; $display("FAIL arith_lat[%0d] got=%0d want=33", i, cycles); end
      checks++;
      if (held !== 1'b1)
        begin errors++; $display("FAIL arith_hold[%0d] got=changed want=held", i); end
    end
  endtask

  task automatic test_mt_and_ignore();
    logic [63:0] e;
    do_reset();
    run_op(OpMthi, 32'h1234_5678, 32'd0, {32'h1234_5678, 32'd0}, -1);
    e = exp_q.pop_front();
    checks++;
    if ({obs_hi, obs_lo} !== e) begin errors++; $display("FAIL mthi got=%h_%h want=%h", obs_hi, obs_lo, e); end
    checks++;
    if (cycles != 0) begin errors++; $display("FAIL mthi_busy got=%0d want=0", cycles); end
    run_op(OpMtlo, 32'h0000_CAFE, 32'd0, {32'h1234_5678, 32'h0000_CAFE}, -1);
    e = exp_q.pop_front();
    checks++;
    if ({obs_hi, obs_lo} !== e) begin errors++; $display("FAIL mtlo got=%h_%h want=%h", obs_hi, obs_lo, e); end
    run_op(OpRsvd, 32'hAAAA_AAAA, 32'd1, {32'h1234_5678, 32'h0000_CAFE}, -1);
    e = exp_q.pop_front();
    checks++;
    if ({obs_hi, obs_lo} !== e) begin errors++; $display("FAIL rsvd got=%h_%h want=%h", obs_hi, obs_lo, e); end
    checks++;
    if (cycles != 0) begin errors++; $display("FAIL rsvd_busy got=%0d want=0", cycles); end
    run_op(OpNone, 32'h5555_5555, 32'd3, {32'h1234_5678, 32'h0000_CAFE}, -1);
    e = exp_q.pop_front();
    checks++;
    if ({obs_hi, obs_lo} !== e) begin errors++; $display("FAIL none got=%h_%h want=%h", obs_hi, obs_lo, e); end
    // MTLO pulsed mid-multiply must be ignored
    run_op(OpMultu, 32'd3, 32'd4, {32'd0, 32'd12}, 5);
    e = exp_q.pop_front();
    checks++;
    if ({obs_hi, obs_lo} !== e) begin errors++; $display("FAIL busy_mt got=%h_%h want=%h", obs_hi, obs_lo, e); end
    checks++;
    if (held !== 1'b1) begin errors++; $display("FAIL busy_mt_hold got=changed want=held"); end
    checks++;
    if (cycles != 33) begin errors++; $display("FAIL busy_mt_lat got=%0d want=33", cycles); end
  endtask

  task automatic test_reset_abort();
    logic [63:0] e;
    run_op(OpMthi, 32'h0000_1111, 32'd0, {32'h0000_1111, 32'd12}, -1);
    e = exp_q.pop_front();
    run_op(OpMtlo, 32'h0000_2222, 32'd0, {32'h0000_1111, 32'h0000_2222}, -1);
    e = exp_q.pop_front();
    checks++;
    if ({HI, LO} !== e) begin errors++; $display("FAIL abort_pre got=%h_%h want=%h", HI, LO, e); end
    @(negedge clk);
    start = 1'b1; MDUop = OpDivu; A = 32'd100; B = 32'd7;
    @(negedge clk);
    start = 1'b0; MDUop = OpNone;
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL abort_inflight got=%b want=1", busy); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({busy, HI, LO} !== 65'd0)
      begin errors++; $display("FAIL abort_clear got=%b_%h_%h want=0_0_0", busy, HI, LO); end
    #1 reset = 1'b1;
    run_op(OpDivu, 32'd100, 32'd7, {32'd2, 32'd14}, -1);
    e = exp_q.pop_front();
    checks++;
    if ({obs_hi, obs_lo} !== e) begin errors++; $display("FAIL abort_redo got=%h_%h want=%h", obs_hi, obs_lo, e); end
    checks++;
    if (cycles != 33) begin errors++; $display("FAIL abort_redo_lat got=%0d want=33", cycles); end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [63:0] e;
    for (int i = 0; i < 16; i++) begin
      op = 3'($urandom_range(1, 4));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_op(op, a, b, model(op, a, b), -1);
      e = exp_q.pop_front();
      checks++;
      if ({obs_hi, obs_lo} !== e)
        begin errors++; $display("FAIL rand[%0d] op=%0d a=%h b=%h got=%h_%h want=%h",
                                 i, op, a, b, obs_hi, obs_lo, e); end
      checks++;
      if (cycles != 33) begin errors++; $display("FAIL rand_lat[%0d] got=%0d want=33", i, cycles); end
    end
  endtask

  initial begin
    test_reset();
    test_arith_table();
    test_mt_and_ignore();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit.
- Sits beside the ALU in the EX stage and handles the MULT/MULTU/DIV/DIVU/MTHI/MTLO class of instructions.
- Multiplication runs as repeated shift-add; division runs as repeated shift-subtract (restoring). Both use one bit per cycle and write the HI/LO result registers.
- Raises busy so hazard control stalls the pipeline for any instruction that touches HI/LO.

Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH each, and the iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- start  input  1  launch request, sampled on the rising clk edge.
- MDUop  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
- A  input  WIDTH  rs operand (dividend/multiplicand; data source for MTHI/MTLO).
- B  input  WIDTH  rt operand (divisor/multiplier).
- busy  output  1  high while an operation is in flight.
- HI  output  WIDTH  HI register (product high half / remainder).
- LO  output  WIDTH  LO register (product low half / quotient).

Behaviour:
- Reset (reset=0, asynchronous): HI=0, LO=0, busy=0, state=IDLE, all internal registers cleared. An in-flight operation is aborted with no partial writeback.
- States are IDLE, RUN and FIX.
- IDLE, start=1, MDUop in {1..4}, sampled at edge T:
  - Latch |A| and |B| for signed ops, or raw A and B for unsigned ops.
  - Latch the sign flags: qsign=A[msb]^B[msb], rsign=A[msb] (both forced to 0 for unsigned ops).
  - Clear the iteration counter, go to RUN, and drive busy=1 after T.
- RUN: one iteration per cycle for WIDTH cycles.
  - Multiply: conditional add of the multiplicand into a 2*WIDTH accumulator, then shift right.
  - Divide: shift the remainder left, trial-subtract the divisor, set the quotient bit when the difference is non-negative.
  - After the WIDTH-th iteration, go to FIX.
- FIX (1 cycle):
  - Apply sign correction. A signed product is negated as a full 2*WIDTH value when qsign=1. The quotient is negated when qsign=1; the remainder is negated when rsign=1.
  - Write HI/LO and go to IDLE; busy=0 after the same edge.
- Latency: start sampled at edge T -> busy=1 after edges T..T+32 (33 cycles) -> new HI/LO visible and busy=0 after edge T+33.
- HI/LO hold their previous values for the whole time busy=1.
- Operand widths and arithmetic rules:
  - |x| is computed as an unsigned WIDTH value, so |0x80000000| = 0x80000000.
  - The multiply accumulator is 2*WIDTH+1 bits so the carry is not lost.
  - The divider remainder register is WIDTH+1 bits.
- MTHI/MTLO with start=1 in IDLE: HI<=A or LO<=A at that edge, single cycle, busy stays 0.
- start=1 while busy=1: ignored for all ops, including MTHI/MTLO. Control never issues this, but the unit must stay robust to it.
- start=1 with NONE or reserved: no effect.
- Divide by zero (B=0): full 33-cycle latency; result is forced to LO=all ones and HI=original A, regardless of signedness (no sign fixup).
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0; this falls out of the magnitude method and needs no special case.
- A and B may change after the start edge; only the latched copies are used.

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. busy high for exactly 33 cycles; HI/LO unchanged until busy falls.
- MULT A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0.
- DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 -> LO=3, HI=1. DIV A=7, B=0xFFFFFFFE -> LO=0xFFFFFFFD, HI=1.
- Boundaries: DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU A=5, B=0 -> LO=0xFFFFFFFF, HI=5 after 33 cycles.
- MTHI A=0x12345678 in IDLE -> HI=0x12345678 next edge, busy stays 0. Then start a MULTU 3x4, and at cycle 5 pulse start with MTLO A=0xDEAD -> ignored; final HI=0, LO=12.
- Start a DIVU 100/7 and pull reset low mid-cycle at RUN iteration 10 -> busy, HI and LO read 0 immediately with no clock edge needed. After release, DIVU 100/7 completes to LO=14, HI=2 in 33 cycles.
